// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// Module : vector_pkg
// Brief  : Shared fixed-point container, sequencer states and sizing helper.
// Rev    : 1.0 - initial release
// ============================================================================
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

package vector_pkg;

    localparam int c_fp_w      = 32;
    localparam int c_frac_bits = 16;

    typedef logic [c_fp_w-1:0] fp;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // A dimension of 1 still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_coord_sequencer_credit_counter.sv
`default_nettype none
// ============================================================================
// Module : credit_counter
// Brief  : Outstanding-pixel counter with saturation guard and sticky underflow.
// Rev    : 1.0 - initial release
// ============================================================================
module credit_counter #(
    parameter int MAX_COUNT = 16,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_underflow
);

    logic [CW-1:0] r_count;
    logic          r_underflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            unique case ({i_inc, i_dec})
                2'b10: if (r_count < CW'(MAX_COUNT)) r_count <= r_count + 1'b1;
                2'b01: begin
                    // A return with nothing outstanding is a downstream protocol error.
                    if (r_count != '0) r_count <= r_count - 1'b1;
                    else               r_underflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: rtl/pixel_coord_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pixel_coord_sequencer
// Brief  : Credit-flow-controlled raster source of per-pixel screen coordinates.
// Rev    : 1.0 - initial release
// ============================================================================
module pixel_coord_sequencer
    import vector_pkg::*;
#(
    parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
    parameter int MAX_IN_FLIGHT = 16,
    localparam int IF_W         = $clog2(MAX_IN_FLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            credit_return,
    output fp               screen_x,
    output fp               screen_y,
    output logic            coords_valid,
    output logic            sof,
    output logic            eof,
    output logic            busy,
    output logic            frame_done,
    output logic [IF_W-1:0] in_flight,
    output logic            credit_error
);

    localparam int c_x_w = cnt_w(SCREEN_WIDTH);
    localparam int c_y_w = cnt_w(SCREEN_HEIGHT);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [c_x_w-1:0] r_x;
    logic [c_y_w-1:0] r_y;
    fp                r_sx;
    fp                r_sy;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;
    logic [IF_W-1:0]  w_in_flight;
    logic             w_underflow;
    logic             w_issue;
    logic             w_last_x;
    logic             w_last_y;

    assign w_last_x = (r_x == c_x_w'(SCREEN_WIDTH - 1));
    assign w_last_y = (r_y == c_y_w'(SCREEN_HEIGHT - 1));
    // Issue gates on the registered count, so a credit returned this edge helps next edge.
    assign w_issue  = (r_state == RUN) && (w_in_flight < IF_W'(MAX_IN_FLIGHT));

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_issue && w_last_x && w_last_y) w_next = DRAIN;
            DRAIN:   if (w_in_flight == '0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_valid <= w_issue;
            r_sof   <= w_issue && (r_x == '0) && (r_y == '0);
            r_eof   <= w_issue && w_last_x && w_last_y;
            if (w_issue) begin
                r_sx <= {{(c_fp_w - c_x_w){1'b0}}, r_x};
                r_sy <= {{(c_fp_w - c_y_w){1'b0}}, r_y};
                // Both counters wrap on the final pixel, leaving them ready for the next frame.
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= w_last_y ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    credit_counter #(
        .MAX_COUNT (MAX_IN_FLIGHT),
        .CW        (IF_W)
    ) u_credits (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_issue),
        .i_dec       (credit_return),
        .o_count     (w_in_flight),
        .o_underflow (w_underflow)
    );

    assign screen_x     = r_sx;
    assign screen_y     = r_sy;
    assign coords_valid = r_valid;
    assign sof          = r_sof;
    assign eof          = r_eof;
    assign busy         = (r_state == RUN) || (r_state == DRAIN);
    assign frame_done   = (r_state == DONE);
    assign in_flight    = w_in_flight;
    assign credit_error = w_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pixel_coord_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pixel_coord_sequencer
// Brief  : Directed self-checking bench for pixel_coord_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pixel_coord_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut_a: 4x2, 16 credits
    logic a_rst, a_start, a_credit;
    logic [31:0] a_sx, a_sy;
    logic a_valid, a_sof, a_eof, a_busy, a_done, a_cerr;
    logic [4:0] a_if;
    // dut_b: 4x2, 2 credits
    logic b_rst, b_start, b_credit;
    logic [31:0] b_sx, b_sy;
    logic b_valid, b_sof, b_eof, b_busy, b_done, b_cerr;
    logic [1:0] b_if;
    // dut_c: 640x3, 16 credits
    logic c_rst, c_start, c_credit;
    logic [31:0] c_sx, c_sy;
    logic c_valid, c_sof, c_eof, c_busy, c_done, c_cerr;
    logic [4:0] c_if;
    // dut_d: 1x1, 16 credits
    logic d_rst, d_start, d_credit;
    logic [31:0] d_sx, d_sy;
    logic d_valid, d_sof, d_eof, d_busy, d_done, d_cerr;
    logic [4:0] d_if;

    pixel_coord_sequencer #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .MAX_IN_FLIGHT(16)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .credit_return(a_credit),
        .screen_x(a_sx), .screen_y(a_sy), .coords_valid(a_valid), .sof(a_sof), .eof(a_eof),
        .busy(a_busy), .frame_done(a_done), .in_flight(a_if), .credit_error(a_cerr));

    pixel_coord_sequencer #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .MAX_IN_FLIGHT(2)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .credit_return(b_credit),
        .screen_x(b_sx), .screen_y(b_sy), .coords_valid(b_valid), .sof(b_sof), .eof(b_eof),
        .busy(b_busy), .frame_done(b_done), .in_flight(b_if), .credit_error(b_cerr));

    pixel_coord_sequencer #(.SCREEN_WIDTH(640), .SCREEN_HEIGHT(3), .MAX_IN_FLIGHT(16)) dut_c (
        .clk(clk), .rst(c_rst), .start(c_start), .credit_return(c_credit),
        .screen_x(c_sx), .screen_y(c_sy), .coords_valid(c_valid), .sof(c_sof), .eof(c_eof),
        .busy(c_busy), .frame_done(c_done), .in_flight(c_if), .credit_error(c_cerr));

    pixel_coord_sequencer #(.SCREEN_WIDTH(1), .SCREEN_HEIGHT(1), .MAX_IN_FLIGHT(16)) dut_d (
        .clk(clk), .rst(d_rst), .start(d_start), .credit_return(d_credit),
        .screen_x(d_sx), .screen_y(d_sy), .coords_valid(d_valid), .sof(d_sof), .eof(d_eof),
        .busy(d_busy), .frame_done(d_done), .in_flight(d_if), .credit_error(d_cerr));

    logic [2:0] a_sr = 3'b000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dut_a returns each pixel's credit so it is sampled three edges after its beat.
    task automatic tick_a();
        tick();
        a_sr     = {a_sr[1:0], a_valid};
        a_credit = a_sr[2];
    endtask

    task automatic expb(input string tag, input logic v, input int x, input int y, input int inf);
        chk({tag, "_valid"}, b_valid, v);
        if (v) begin
            chk({tag, "_x"}, b_sx, x);
            chk({tag, "_y"}, b_sy, y);
        end
        chk({tag, "_inflight"}, b_if, inf);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, done_idx, extra, beats, sof_extra, ex, ey, wx, wy;
        logic eof_found, early_done;

        a_rst = 0; a_start = 0; a_credit = 0;
        b_rst = 0; b_start = 0; b_credit = 0;
        c_rst = 0; c_start = 0; c_credit = 0;
        d_rst = 0; d_start = 0; d_credit = 0;
        tick(); tick();
        a_rst = 1; b_rst = 1; c_rst = 1; d_rst = 1;
        tick();

        // ---- reset state ----
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_sx", a_sx, 0);
        chk("rst_a_sy", a_sy, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_inflight", a_if, 0);
        chk("rst_a_cerr", a_cerr, 0);
        chk("rst_b_inflight", b_if, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_d_busy", d_busy, 0);

        // ---- A: full 4x2 frame, credits back after 3 cycles, start during RUN/DRAIN ----
        a_start = 1;
        tick_a();
        a_start = 0;
        chk("a_busy_after_start", a_busy, 1);
        chk("a_no_beat_yet", a_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick_a();
            a_start = 0;
            chk("a_valid", a_valid, 1);
            chk("a_x", a_sx, i % 4);
            chk("a_y", a_sy, i / 4);
            chk("a_sof", a_sof, (i == 0));
            chk("a_eof", a_eof, (i == 7));
            chk("a_inflight", a_if, (i + 1) - ((i > 2) ? (i - 2) : 0));
            if (i == 3) a_start = 1;
        end
        done_cnt = 0; done_idx = -1; extra = 0;
        for (int d = 1; d <= 10; d++) begin
            tick_a();
            a_start = 0;
            if (a_done) begin
                done_cnt++;
                done_idx = d;
            end
            if (a_valid) extra++;
            if (d == 1) begin
                chk("a_drain_busy", a_busy, 1);
                chk("a_drain_inflight", a_if, 2);
                a_start = 1;
            end
        end
        chk("a_done_count", done_cnt, 1);
        chk("a_done_cycle", done_idx, 4);
        chk("a_extra_beats", extra, 0);
        chk("a_busy_end", a_busy, 0);
        chk("a_inflight_end", a_if, 0);
        chk("a_cerr_end", a_cerr, 0);

        // ---- B: credit starvation, then steady issue with credit held high ----
        b_start = 1;
        tick();
        b_start = 0;
        expb("b0", 0, 0, 0, 0);
        tick(); expb("b1", 1, 0, 0, 1);
        chk("b1_sof", b_sof, 1);
        tick(); expb("b2", 1, 1, 0, 2);
        tick(); expb("b3", 0, 0, 0, 2);
        tick(); expb("b4", 0, 0, 0, 2);
        b_credit = 1;
        tick(); expb("b5", 0, 0, 0, 1);
        b_credit = 0;
        tick(); expb("b6", 1, 2, 0, 2);
        tick(); expb("b7", 0, 0, 0, 2);
        b_credit = 1;
        tick(); expb("b8", 0, 0, 0, 1);
        tick(); expb("b9", 1, 3, 0, 1);
        tick(); expb("b10", 1, 0, 1, 1);
        tick(); expb("b11", 1, 1, 1, 1);
        tick(); expb("b12", 1, 2, 1, 1);
        tick(); expb("b13", 1, 3, 1, 1);
        chk("b13_eof", b_eof, 1);
        tick(); expb("b14", 0, 0, 0, 0);
        chk("b14_busy", b_busy, 1);
        b_credit = 0;
        tick();
        chk("b15_done", b_done, 1);
        tick();
        chk("b16_done", b_done, 0);
        chk("b16_busy", b_busy, 0);
        chk("b16_cerr", b_cerr, 0);

        // ---- E: credit return while idle with nothing outstanding ----
        b_credit = 1;
        tick();
        b_credit = 0;
        chk("e_cerr_set", b_cerr, 1);
        chk("e_inflight_zero", b_if, 0);
        tick(); tick();
        chk("e_cerr_sticky", b_cerr, 1);

        // ---- D: reset mid-frame at (2,1) with 5 outstanding ----
        a_start = 1;
        tick();
        a_start = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) a_credit = 1;
            if (i == 2) a_credit = 0;
        end
        chk("d_pre_x", a_sx, 2);
        chk("d_pre_y", a_sy, 1);
        chk("d_pre_inflight", a_if, 5);
        a_rst = 0;
        tick();
        chk("d_rst_valid", a_valid, 0);
        chk("d_rst_x", a_sx, 0);
        chk("d_rst_y", a_sy, 0);
        chk("d_rst_sof", a_sof, 0);
        chk("d_rst_eof", a_eof, 0);
        chk("d_rst_busy", a_busy, 0);
        chk("d_rst_inflight", a_if, 0);
        chk("d_rst_done", a_done, 0);
        a_rst = 1;
        early_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_done || a_valid) early_done = 1;
        end
        chk("d_quiet_after_rst", early_done, 0);
        a_start = 1;
        tick();
        a_start = 0;
        tick();
        chk("d_restart_valid", a_valid, 1);
        chk("d_restart_x", a_sx, 0);
        chk("d_restart_y", a_sy, 0);
        chk("d_restart_sof", a_sof, 1);
        a_rst = 0;
        tick();
        a_rst = 1;

        // ---- C: wide raster, one beat per cycle with credit held ----
        c_start = 1;
        tick();
        c_start = 0;
        tick();
        chk("c_first_valid", c_valid, 1);
        chk("c_first_sof", c_sof, 1);
        beats = 1; sof_extra = 0; eof_found = 0; ex = -1; ey = -1; wx = -1; wy = -1;
        c_credit = 1;
        for (int n = 0; n < 3000 && !eof_found; n++) begin
            tick();
            if (c_valid) begin
                if (beats == 640) begin
                    wx = c_sx;
                    wy = c_sy;
                end
                beats++;
                if (c_sof) sof_extra++;
                if (c_eof) begin
                    eof_found = 1;
                    ex = c_sx;
                    ey = c_sy;
                end
            end
        end
        chk("c_eof_found", eof_found, 1);
        chk("c_beats", beats, 1920);
        chk("c_eof_x", ex, 639);
        chk("c_eof_y", ey, 2);
        chk("c_wrap_x", wx, 0);
        chk("c_wrap_y", wy, 1);
        chk("c_sof_once", sof_extra, 0);
        chk("c_eof_inflight", c_if, 1);
        tick();
        c_credit = 0;
        chk("c_drain_inflight", c_if, 0);
        tick();
        chk("c_done", c_done, 1);
        chk("c_cerr", c_cerr, 0);

        // ---- single-pixel frame ----
        d_start = 1;
        tick();
        d_start = 0;
        tick();
        chk("s_valid", d_valid, 1);
        chk("s_sof", d_sof, 1);
        chk("s_eof", d_eof, 1);
        chk("s_x", d_sx, 0);
        tick();
        chk("s_no_second_beat", d_valid, 0);
        chk("s_drain_busy", d_busy, 1);
        d_credit = 1;
        tick();
        d_credit = 0;
        chk("s_inflight", d_if, 0);
        tick();
        chk("s_done", d_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
